// File: rtl/sigma_delta_cic_decimator.sv
// Sinc^N (CIC) decimator for a 1-bit sigma-delta bitstream.
// ORDER integrators run at the bitstream rate, gated by 'en'. A counter
// raises a decimation event once every 2^LOG2_RATE accepted bits. On that
// event, ORDER comb stages take differences of the last integrator across
// frames. The comb result is scaled and clamped to OUT_WIDTH bits, then
// registered together with a one-cycle valid pulse.
// Internal arithmetic is K+2 bits wide and wraps on overflow. The CIC
// response stays bounded, so wrap-around inside the chain cancels out at
// the comb output.

module sigma_delta_cic_decimator #(
    parameter int unsigned ORDER     = 3,
    parameter int unsigned LOG2_RATE = 6,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 outValid,
    output logic                 sat
);

    // Bit growth of a sinc^N filter with ratio 2^LOG2_RATE.
    localparam int unsigned K     = ORDER * LOG2_RATE;
    // One bit covers +2^K and one more bit gives wrap headroom.
    localparam int unsigned W     = K + 2;
    // Drop LSBs so that +/-2^K maps onto the OUT_WIDTH-bit range.
    localparam int unsigned SHIFT = K + 1 - OUT_WIDTH;

    // Largest positive output, held in the internal width for comparison.
    localparam logic signed [W-1:0] OUT_MAX =
        {{(W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]         integ_q [ORDER];
    logic [W-1:0]         integ_d [ORDER];
    logic [W-1:0]         dly_q   [ORDER];
    logic [W-1:0]         dly_d   [ORDER];
    logic [LOG2_RATE-1:0] cnt_q;
    logic [LOG2_RATE-1:0] cnt_d;
    logic [OUT_WIDTH-1:0] out_q;
    logic [OUT_WIDTH-1:0] out_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 sat_q;
    logic                 sat_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [W-1:0]        x_ext;
    logic                dec_evt;
    logic [W-1:0]        stage_in [ORDER];
    logic [W-1:0]        comb_out;
    logic signed [W-1:0] scaled;
    logic                clamp;

    // Map the bitstream bit to +1 / -1 in the internal width.
    always_comb begin
        x_ext = in ? W'(1) : '1;
    end

    // A frame ends on the accepted bit that finds the counter at R-1.
    always_comb begin
        dec_evt = en && (cnt_q == '1);
    end

    // Count accepted bits. R is a power of two, so the wrap is implicit.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + LOG2_RATE'(1);
        end
    end

    // Cascade the integrators. Every stage adds the previous stage's old value.
    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (en) begin
            integ_d[0] = integ_q[0] + x_ext;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    // Build the comb chain as a combinational ripple from the last integrator.
    always_comb begin
        logic [W-1:0] acc;
        acc = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            stage_in[k] = acc;
            acc         = acc - dly_q[k];
        end
        comb_out = acc;
    end

    // On a decimation event, capture each comb stage's input as its new delay.
    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            dly_d[k] = dec_evt ? stage_in[k] : dly_q[k];
        end
    end

    // Scale with flooring and clamp. Only the +2^K extreme can overflow.
    always_comb begin
        scaled = $signed(comb_out) >>> SHIFT;
        clamp  = (scaled > OUT_MAX);
    end

    // Output registers update only on a decimation event; otherwise they hold.
    always_comb begin
        out_valid_d = dec_evt;
        out_d       = out_q;
        sat_d       = sat_q;
        if (dec_evt) begin
            if (clamp) begin
                out_d = OUT_MAX[OUT_WIDTH-1:0];
                sat_d = 1'b1;
            end else begin
                out_d = scaled[OUT_WIDTH-1:0];
                sat_d = 1'b0;
            end
        end
    end

    // Hold all state in registers. An asynchronous reset drops any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out      = out_q;
    assign outValid = out_valid_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_sigma_delta_cic_decimator.sv
// Bench for sigma_delta_cic_decimator.
// The reference is an FIR model. Each output equals the bitstream convolved
// with (boxcar of length R)^ORDER, delayed by ORDER samples and taken once
// per frame. The result is then scaled and clamped.
module tb_sigma_delta_cic_decimator;

    localparam int ORDER     = 3;
    localparam int LOG2_RATE = 6;
    localparam int OUT_WIDTH = 16;
    localparam int R         = 1 << LOG2_RATE;
    localparam int K         = ORDER * LOG2_RATE;
    localparam int SHIFT     = K + 1 - OUT_WIDTH;
    localparam int HLEN      = ORDER * (R - 1) + 1;
    localparam longint OUT_MAX = (64'sd1 <<< (OUT_WIDTH - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 in_bit = 1'b0;
    logic [OUT_WIDTH-1:0] out;
    logic                 out_valid;
    logic                 sat;

    int vectors = 0;
    int miscompares = 0;

    int                   xs[$];
    longint               h[HLEN];
    int                   n_out;
    logic [OUT_WIDTH-1:0] exp_out;
    logic                 exp_sat;

    sigma_delta_cic_decimator #(
        .ORDER     (ORDER),
        .LOG2_RATE (LOG2_RATE),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in       (in_bit),
        .out      (out),
        .outValid (out_valid),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    // Impulse response of the sinc^ORDER filter: repeated boxcar convolution.
    function automatic void build_kernel();
        longint tmp[HLEN];
        int len;
        foreach (h[i]) h[i] = 0;
        h[0] = 1;
        len = 1;
        for (int s = 0; s < ORDER; s++) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++)
                    tmp[i+j] += h[i];
            len += R - 1;
            h = tmp;
        end
    endfunction

    // Filter output at sample index t. Samples from before the last reset are zero.
    function automatic longint ref_v(int t);
        longint acc = 0;
        for (int j = 0; j < HLEN; j++) begin
            int idx = t - ORDER - j;
            if (idx >= 0) acc += h[j] * longint'(xs[idx]);
        end
        return acc;
    endfunction

    // One clock with the given inputs, then check every output against the model.
    task automatic step(input logic e, input logic b, input bit chk_steady,
                        input logic [OUT_WIDTH-1:0] st_out, input logic st_sat,
                        input string name);
        bit     d;
        longint v;
        longint y;
        en     = e;
        in_bit = b;
        @(posedge clk);
        #1;
        if (e) xs.push_back(b ? 1 : -1);
        d = e && (xs.size() % R == 0);
        if (d) begin
            v = ref_v(xs.size() - 1);
            y = v >>> SHIFT;
            if (y > OUT_MAX) begin
                exp_out = OUT_MAX[OUT_WIDTH-1:0];
                exp_sat = 1'b1;
            end else begin
                exp_out = y[OUT_WIDTH-1:0];
                exp_sat = 1'b0;
            end
            n_out++;
        end
        vectors++;
        if (out_valid !== d) begin
            miscompares++;
            $display("FAIL %s outValid: got %0b want %0b (sample %0d)", name, out_valid, d,
                     xs.size());
        end
        vectors++;
        if (out !== exp_out) begin
            miscompares++;
            $display("FAIL %s out: got %h want %h (output %0d)", name, out, exp_out, n_out);
        end
        vectors++;
        if (sat !== exp_sat) begin
            miscompares++;
            $display("FAIL %s sat: got %0b want %0b (output %0d)", name, sat, exp_sat, n_out);
        end
        if (d && chk_steady && n_out >= ORDER + 2) begin
            vectors++;
            if (out !== st_out || sat !== st_sat) begin
                miscompares++;
                $display("FAIL %s steady: got out=%h sat=%0b want out=%h sat=%0b", name, out,
                         sat, st_out, st_sat);
            end
        end
    endtask

    // Assert reset between edges and check that it takes effect at once; release on negedge.
    task automatic do_reset(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out !== '0 || out_valid !== 1'b0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL %s async reset: got out=%h outValid=%0b sat=%0b want 0/0/0", name,
                     out, out_valid, sat);
        end
        xs.delete();
        n_out   = 0;
        exp_out = '0;
        exp_sat = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (out !== '0 || out_valid !== 1'b0 || sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%h outValid=%0b sat=%0b want 0/0/0", out,
                     out_valid, sat);
        end
        xs.delete();
        n_out   = 0;
        exp_out = '0;
        exp_sat = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset in the middle of a frame; the next pulse must come R en-cycles after release.
    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2 * R + 36; i++) step(1'b1, 1'($urandom), 1'b0, '0, 1'b0, "midrst_pre");
        en = 1'b1;
        do_reset("midrst");
        for (int i = 0; i < R + 4; i++) step(1'b1, 1'($urandom), 1'b0, '0, 1'b0, "midrst_post");
    endtask

    task automatic test_pattern(input logic [3:0] pat, input int plen,
                                input logic [OUT_WIDTH-1:0] st_out, input logic st_sat,
                                input string name);
        do_reset(name);
        for (int i = 0; i < 8 * R; i++) step(1'b1, pat[i % plen], 1'b1, st_out, st_sat, name);
    endtask

    // Full-scale input with en only every third cycle; 'in' is random while en is low.
    task automatic test_sparse_en();
        do_reset("sparse_en");
        for (int i = 0; i < 8 * R * 3; i++) begin
            if (i % 3 == 0) step(1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, "sparse_en");
            else step(1'b0, 1'($urandom), 1'b1, 16'h7FFF, 1'b1, "sparse_en");
        end
    endtask

    task automatic test_random();
        do_reset("random");
        for (int i = 0; i < 3000; i++) begin
            if (i == 1700) do_reset("random_rst");
            step(1'($urandom_range(3, 0) != 0), 1'($urandom), 1'b0, '0, 1'b0, "random");
        end
    endtask

    // Runs of mostly ones or mostly zeros, to drive the output toward both extremes.
    task automatic test_biased();
        do_reset("biased");
        for (int i = 0; i < 2000; i++) begin
            logic b;
            if ((i / 400) % 2 == 0) b = ($urandom_range(15, 0) != 0);
            else b = ($urandom_range(15, 0) == 0);
            step(1'b1, b, 1'b0, '0, 1'b0, "biased");
        end
    endtask

    initial begin
        build_kernel();
        test_reset();
        test_reset_mid_frame();
        test_pattern(4'b0001, 1, 16'h7FFF, 1'b1, "const_one");
        test_pattern(4'b0000, 1, 16'h8000, 1'b0, "const_zero");
        test_pattern(4'b0101, 2, 16'h0000, 1'b0, "alternating");
        test_pattern(4'b0111, 4, 16'h4000, 1'b0, "three_quarter");
        test_sparse_en();
        test_random();
        test_biased();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
